// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver (LSB-first, optional parity, one-cycle result strobes).
// Define UART_RX_MAJORITY_VOTE_EN for a 3-sample majority vote around mid-bit instead of a single sample.
module uart_rx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic [5:0]            prescale,
    output logic [DATA_WIDTH-1:0] p_data,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  r_sync1;
    logic                  r_sync2;
    logic                  w_rx_s;
    logic [5:0]            r_prescale;
    logic                  r_par_en;
    logic                  r_par_typ;
    logic [5:0]            r_edge_cnt;
    logic [BW-1:0]         r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_par_bad;
    logic [5:0]            w_mid;
    logic                  w_bit_end;
    logic                  w_decide;
    logic                  w_bit;
    logic                  w_start;

    assign w_rx_s    = r_sync2;
    assign w_mid     = {1'b0, r_prescale[5:1]};
    assign w_bit_end = (r_edge_cnt == (r_prescale - 6'd1));
    assign w_start   = (r_state == S_IDLE) && (w_next == S_START);

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic r_smp0;
    logic r_smp1;

    // Two early samples are held; the third is the live line value at the decision point.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_smp0 <= 1'b1;
            r_smp1 <= 1'b1;
        end else begin
            if (r_edge_cnt == (w_mid - 6'd1)) r_smp0 <= w_rx_s;
            if (r_edge_cnt == w_mid)          r_smp1 <= w_rx_s;
        end
    end

    assign w_decide = (r_edge_cnt == (w_mid + 6'd1));
    assign w_bit    = (r_smp0 & r_smp1) | (r_smp0 & w_rx_s) | (r_smp1 & w_rx_s);
`else
    assign w_decide = (r_edge_cnt == w_mid);
    assign w_bit    = w_rx_s;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx_in;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (!w_rx_s) w_next = S_START;
            S_START: begin
                if (w_decide && w_bit) w_next = S_IDLE;
                else if (w_bit_end)    w_next = S_DATA;
            end
            S_DATA: begin
                if (w_bit_end && (r_bit_cnt == BW'(DATA_WIDTH - 1)))
                    w_next = r_par_en ? S_PARITY : S_STOP;
            end
            S_PARITY: if (w_bit_end) w_next = S_STOP;
            // Leave mid-stop-bit so a start edge right after the stop bit is not missed.
            S_STOP:   if (w_decide) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_edge_cnt <= '0;
            r_bit_cnt  <= '0;
        end else begin
            if ((r_state == S_IDLE) || (w_next == S_IDLE) || w_bit_end) r_edge_cnt <= '0;
            else                                                        r_edge_cnt <= r_edge_cnt + 6'd1;
            if (r_state != S_DATA) r_bit_cnt <= '0;
            else if (w_bit_end)    r_bit_cnt <= r_bit_cnt + BW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prescale <= 6'd8;
            r_par_en   <= 1'b0;
            r_par_typ  <= 1'b0;
            r_shift    <= '0;
            r_par_bad  <= 1'b0;
            p_data     <= '0;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
            if (w_start) begin
                r_prescale <= prescale;
                r_par_en   <= par_en;
                r_par_typ  <= par_typ;
                r_par_bad  <= 1'b0;
            end
            if (w_decide) begin
                case (r_state)
                    S_DATA:   r_shift   <= {w_bit, r_shift[DATA_WIDTH-1:1]};
                    // Mismatch against ^data (even) or ~^data (odd).
                    S_PARITY: r_par_bad <= w_bit ^ (^r_shift) ^ r_par_typ;
                    S_STOP: begin
                        par_err <= r_par_bad;
                        stp_err <= ~w_bit;
                        if (w_bit && !r_par_bad) begin
                            p_data     <= r_shift;
                            data_valid <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver, the receive half of the UART alongside the TX FSM/serializer. It oversamples `rx_in` at `prescale` clocks per bit and detects the start bit. It deserializes LSB-first data, checks optional parity and the stop bit, then presents a parallel word with a one-cycle `data_valid` strobe to the system controller / RX CDC path.

## Interface

Parameters:
- `DATA_WIDTH`, default 8: data bits per frame.

Ports:
- `clk` in 1: oversampling clock (UART RX clock domain).
- `rst` in 1: reset, asynchronous, active-low.
- `rx_in` in 1: serial line, idle high, asynchronous to `clk`.
- `par_en` in 1: 1 = frame carries a parity bit.
- `par_typ` in 1: 0 = even, 1 = odd.
- `prescale` in 6: oversampling ratio; legal values are 8, 16 and 32, all others are undefined.
- `p_data` out DATA_WIDTH: received word, held until the next good frame.
- `data_valid` out 1: one-cycle strobe, `p_data` is new and error-free.
- `par_err` out 1: one-cycle strobe, parity mismatch.
- `stp_err` out 1: one-cycle strobe, stop bit sampled low.

## Operation

- Input path: `rx_in` passes through a 2-flop synchronizer to give `rx_s`. All logic uses `rx_s`.
- Counters:
  - `edge_cnt` counts 0..prescale-1 within a bit and wraps to 0.
  - `bit_cnt` counts 0..DATA_WIDTH-1 during DATA.
  - `mid` = prescale/2.
- Sample decision: one sampled bit value per frame bit, produced at the decision point (see Configuration).
- Configuration latch: `par_en`, `par_typ` and `prescale` are latched on the IDLE→START transition. Changes mid-frame are ignored.
- States and transitions:
  - IDLE: `edge_cnt`=0. When `rx_s`=0, go to START; `edge_cnt` starts at 0 in the first START cycle.
  - START: at the decision, sampled 1 = glitch, so go to IDLE with no strobes. Otherwise go to DATA when `edge_cnt`=prescale-1.
  - DATA: each decision shifts the bit into the shift register LSB-first (bit 0 first). When `edge_cnt`=prescale-1 and `bit_cnt`=DATA_WIDTH-1, go to PARITY if `par_en`, else STOP.
  - PARITY: the decision compares against `^data` (even) or `~^data` (odd); the result is held internally. When `edge_cnt`=prescale-1, go to STOP.
  - STOP: at the decision, go to IDLE immediately (mid-bit), so a start bit directly after the stop bit is caught.
- Outputs on the STOP decision edge:
  - Good frame: `p_data` ← shift register and `data_valid`=1 for one cycle.
  - Parity error: `par_err`=1 for one cycle.
  - Stop error: `stp_err`=1 for one cycle.
  - Both errors can pulse together. Any error suppresses `data_valid` and leaves `p_data` unchanged.
- Reset values: `p_data`=0, `data_valid`=0, `par_err`=0, `stp_err`=0, state IDLE, counters 0, synchronizer flops 1.
- Reset asserted mid-frame: immediate return to IDLE, no strobes, partial data discarded.
- Line held low (break): a stop error is flagged, then the block re-enters START the cycle after IDLE, since `rx_s` is still 0. No lock-up.

## Timing

- T0 is the first cycle in START; this is 2–3 clk after the falling edge of `rx_in` (synchronizer).
- Frame bit k has start = 0, data = 1..DATA_WIDTH, then parity, then stop. Its decision cycle is T0 + k·prescale + S:
  - S = mid without the macro.
  - S = mid+1 with the macro.
- Stop index n = 1 + DATA_WIDTH + par_en.
- `data_valid`/`par_err`/`stp_err` are high in cycle T0 + n·prescale + S + 1, for exactly 1 cycle.
- Back-to-back frames: the next start edge may arrive immediately after the nominal stop-bit end. The receiver is back in IDLE at least prescale/2−2 cycles before that.

## Configuration

- Macro: `UART_RX_MAJORITY_VOTE_EN`.
- Defined: 3-sample majority vote. Samples are taken at `edge_cnt` = mid−1, mid and mid+1; the decision is made at mid+1 (S = mid+1).
- Undefined: a single sample at `edge_cnt` = mid, with the decision at mid (S = mid).
- Everything else is identical in both builds.

## Test plan

- prescale=8, par_en=0, send 0xA5 with stop=1 -> `data_valid` for 1 cycle at T0+9·8+S+1; `p_data`=0xA5; no errors.
- prescale=16, par_en=1, par_typ=0, send 0x3C with parity bit 0 -> `data_valid`, `p_data`=0x3C. Repeat with parity bit 1 -> `par_err` pulse, no `data_valid`, `p_data` still 0x3C.
- prescale=8, send 0x81 with stop bit 0 -> `stp_err` pulse only. Line then returns high and 0x7E is sent -> `data_valid`, `p_data`=0x7E.
- Low glitch of 2 clk on an idle line (prescale=16) -> block returns to IDLE at the start decision, no strobes. With the macro, a 1-clk low at mid is outvoted; a valid frame follows normally.
- prescale=32, odd parity, three back-to-back frames 0x00, 0xFF, 0x55 with no idle gap -> three `data_valid` strobes spaced exactly 11·32 cycles, correct data each.
- Assert `rst` during DATA bit 4 -> all outputs 0 immediately. After release, the next full frame 0x12 is received correctly.
